rd_return_router: RTL and testbench
===================================

# rd_return_router

AXI read-data (R) return router for the 3-master interconnect. It sits between the single shared slave R channel and the three master R channels, downstream of the read-channel arbiter. It latches the arbiter's one-hot grant, routes each R beat to the owning master, and checks burst length against the accepted AR length. When the burst completes it issues the one-cycle `rd_state_refre` pulse that lets the arbiter rotate priority and release the grant.

## Interface
- `DATA_W`, 32, R data width
- `ID_W`, 4, R ID width
- `sys_clk`  in  1  clock
- `sys_rst`  in  1  reset; asynchronous and active-high
- `rd_grant`  in  3  one-hot grant from arbiter, bit n = master n
- `ar_len`  in  8  AXI ARLEN of the granted master's AR, valid with `ar_hs`
- `ar_hs`  in  1  ARVALID&ARREADY at slave AR port
- `s_rdata`  in  DATA_W  slave R data
- `s_rid`  in  ID_W  slave R ID
- `s_rresp`  in  2  slave R response
- `s_rlast`  in  1  slave R last
- `s_rvalid`  in  1  slave R valid
- `s_rready`  out  1  slave R ready
- `m_rdata`  out  DATA_W  R data broadcast to all masters
- `m_rid`  out  ID_W  R ID broadcast
- `m_rresp`  out  2  R response broadcast
- `m_rlast`  out  1  R last broadcast (corrected, see Operation)
- `m_rvalid`  out  3  per-master R valid, bit n = master n
- `m_rready`  in  3  per-master R ready
- `rd_state_refre`  out  1  one-cycle pulse: burst finished, arbiter may advance
- `len_err`  out  1  one-cycle pulse: RLAST disagreed with ARLEN

## Operation
- The FSM has four states: IDLE, WAIT_AR, DATA, RELEASE. Registers: `owner[1:0]`, `beats_left[7:0]`.
- **IDLE**
  - When `rd_grant` is exactly one-hot, latch `owner`.
  - If `ar_hs` is also high, load `beats_left=ar_len` and go to DATA. Otherwise go to WAIT_AR.
  - When `rd_grant` is 0 or not one-hot, remain in IDLE. A multi-hot grant is ignored.
- **WAIT_AR**
  - On `ar_hs`, load `beats_left=ar_len` and go to DATA.
  - If `rd_grant==0` (request withdrawn), return to IDLE. No refre is issued.
- **DATA**
  - The R path is combinational pass-through.
  - `s_rready=m_rready[owner]`.
  - `m_rvalid[owner]=s_rvalid`; the other `m_rvalid` bits are 0.
  - `m_rdata`/`m_rid`/`m_rresp` = slave values.
  - Beat = `s_rvalid&s_rready`. On a beat with `beats_left!=0` and `s_rlast=0`, decrement.
  - Final beat = beat with `s_rlast=1` or `beats_left==0`. On the final beat go to RELEASE.
  - `m_rlast = s_rlast | (beats_left==0)`. A short RLAST ends the burst early; a missing RLAST is forced on the master side.
  - `len_err` pulses on the final beat when `s_rlast != (beats_left==0)`.
- **RELEASE**
  - `rd_state_refre=1` for exactly this cycle.
  - `s_rready=0`, `m_rvalid=0`.
  - Next state is IDLE unconditionally.
- Outside DATA: `s_rready=0`, `m_rvalid=3'b000`. Data buses may carry slave values; masters qualify them by valid.
- `rd_grant` changes during DATA are ignored; `owner` is held until RELEASE.
- `s_rid` is not checked.

## Timing
- **Reset values:** `s_rready=0`, `m_rvalid=0`, `rd_state_refre=0`, `len_err=0`, state IDLE, `owner=0`, `beats_left=0`. `m_rdata`/`m_rid`/`m_rresp`/`m_rlast` are don't-care while no valid is asserted.
- **Reset mid-burst:** all registers return to reset values immediately, asynchronously. The in-flight burst is abandoned and no refre is issued.
- **Data latency:** 0 cycles (combinational). VALID/READY obey AXI rules; the router never drops a beat and never creates one.
- **Handshake stalls:** a master holding `m_rready=0` stalls the slave via `s_rready`.
- **Grant latch:** the grant is registered on the edge where IDLE sees a one-hot `rd_grant`.
- **Refre timing:** `rd_state_refre` is asserted in the cycle after the final beat's handshake edge. The arbiter clears the grant on that edge, so the next IDLE cycle sees `rd_grant=0` or a fresh grant.
- **Minimum turnaround:** final beat to next DATA entry is 2 cycles (RELEASE, IDLE with `ar_hs`).
- **Burst length:** an `ar_len` of 255 gives a 256-beat burst. `beats_left` never wraps; it is not decremented at 0.

## Test plan
- **Nominal routing:** `rd_grant=010`, `ar_hs` with `ar_len=3`, 4 beats with RLAST on beat 4, `m_rready[1]=1`.
  - Only `m_rvalid[1]` toggles and `m_rlast` is on beat 4.
  - `rd_state_refre` pulses once, 1 cycle after beat 4; `len_err=0`.
- **Backpressure:** same burst, `m_rready[1]` low for 3 cycles mid-burst.
  - `s_rready` is low exactly for those cycles.
  - Data is held and 4 beats are delivered in order.
- **Early RLAST:** `ar_len=3`, slave asserts `s_rlast` on beat 2.
  - Burst ends after 2 beats with `m_rlast` on beat 2.
  - `len_err` pulses with beat 2, then refre pulses.
- **Missing RLAST:** `ar_len=1`, slave sends 2 beats without `s_rlast`.
  - `m_rlast=1` on beat 2 and `len_err` pulses.
  - A third slave beat sees `s_rready=0`.
- **Grant withdrawn and grant+AR same cycle:** `rd_grant=001` then 0 before `ar_hs`.
  - FSM returns to IDLE with no refre.
  - Then `rd_grant=100` with `ar_hs` in the same cycle, `ar_len=0`: a single beat routes to master 2 and refre pulses once.
- **Reset mid-burst:** `sys_rst` asserted during beat 2 of an 8-beat burst.
  - Outputs go to 0 immediately and there is no refre.
  - After release, a new `rd_grant=001` burst completes normally.

Source files
------------

// File: rtl/rd_return_router.sv
// rtl/rd_return_router.sv - AXI R-channel return router for the 3-master read interconnect
//
// Routes the shared slave R channel to the master that owns the current read
// grant, checks the burst length against the accepted ARLEN and pulses
// rd_state_refre once the burst is complete so the arbiter can advance.
//
// Ports:
//   sys_clk, sys_rst        clock, asynchronous active-high reset
//   rd_grant[2:0]           one-hot grant from the read arbiter
//   ar_len[7:0], ar_hs      ARLEN and AR handshake at the slave AR port
//   s_r*                    shared slave R channel (s_rready driven here)
//   m_rdata/m_rid/m_rresp   R payload broadcast to all masters
//   m_rlast                 RLAST broadcast, forced high when the count runs out
//   m_rvalid[2:0]           per-master R valid
//   m_rready[2:0]           per-master R ready
//   rd_state_refre          one-cycle pulse after the final beat
//   len_err                 one-cycle pulse on a final beat whose RLAST disagrees with ARLEN
module rd_return_router #(
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic [2:0]        rd_grant,
  input  logic [7:0]        ar_len,
  input  logic              ar_hs,
  input  logic [DATA_W-1:0] s_rdata,
  input  logic [ID_W-1:0]   s_rid,
  input  logic [1:0]        s_rresp,
  input  logic              s_rlast,
  input  logic              s_rvalid,
  output logic              s_rready,
  output logic [DATA_W-1:0] m_rdata,
  output logic [ID_W-1:0]   m_rid,
  output logic [1:0]        m_rresp,
  output logic              m_rlast,
  output logic [2:0]        m_rvalid,
  input  logic [2:0]        m_rready,
  output logic              rd_state_refre,
  output logic              len_err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_AR = 2'd1,
    DATA    = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t     state;
  logic [1:0] owner;
  logic [7:0] beats_left;

  logic       grant_onehot;
  logic [1:0] grant_idx;
  logic       in_data;
  logic       owner_ready;
  logic       count_done;
  logic       beat;
  logic       final_beat;

  // Multi-hot and zero grants are both rejected here; only a clean one-hot
  // grant starts a burst.
  always_comb begin
    grant_onehot = 1'b0;
    grant_idx    = 2'd0;
    case (rd_grant)
      3'b001: begin grant_onehot = 1'b1; grant_idx = 2'd0; end
      3'b010: begin grant_onehot = 1'b1; grant_idx = 2'd1; end
      3'b100: begin grant_onehot = 1'b1; grant_idx = 2'd2; end
      default: begin grant_onehot = 1'b0; grant_idx = 2'd0; end
    endcase
  end

  always_comb begin
    owner_ready = 1'b0;
    case (owner)
      2'd0:    owner_ready = m_rready[0];
      2'd1:    owner_ready = m_rready[1];
      2'd2:    owner_ready = m_rready[2];
      default: owner_ready = 1'b0;
    endcase
  end

  assign in_data    = (state == DATA);
  assign s_rready   = in_data & owner_ready;
  assign count_done = (beats_left == 8'd0);
  assign beat       = s_rvalid & s_rready;
  // A short RLAST ends the burst early; an exhausted count ends it even
  // without RLAST, so the master always sees a terminated burst.
  assign final_beat = beat & (s_rlast | count_done);
  assign len_err    = final_beat & (s_rlast != count_done);

  assign m_rdata = s_rdata;
  assign m_rid   = s_rid;
  assign m_rresp = s_rresp;
  assign m_rlast = s_rlast | count_done;

  always_comb begin
    m_rvalid = 3'b000;
    if (in_data && s_rvalid) begin
      case (owner)
        2'd0:    m_rvalid = 3'b001;
        2'd1:    m_rvalid = 3'b010;
        2'd2:    m_rvalid = 3'b100;
        default: m_rvalid = 3'b000;
      endcase
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state          <= IDLE;
      owner          <= 2'd0;
      beats_left     <= 8'd0;
      rd_state_refre <= 1'b0;
    end else begin
      rd_state_refre <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_onehot) begin
            owner <= grant_idx;
            if (ar_hs) begin
              beats_left <= ar_len;
              state      <= DATA;
            end else begin
              state <= WAIT_AR;
            end
          end
        end
        WAIT_AR: begin
          if (ar_hs) begin
            beats_left <= ar_len;
            state      <= DATA;
          end else if (rd_grant == 3'b000) begin
            state <= IDLE;
          end
        end
        DATA: begin
          if (final_beat) begin
            state          <= RELEASE;
            rd_state_refre <= 1'b1;
          end else if (beat && !count_done) begin
            beats_left <= beats_left - 8'd1;
          end
        end
        RELEASE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rd_return_router.sv
// tb/tb_rd_return_router.sv - directed self-checking bench for rd_return_router
module tb_rd_return_router;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic [2:0]  rd_grant;
  logic [7:0]  ar_len;
  logic        ar_hs;
  logic [31:0] s_rdata;
  logic [3:0]  s_rid;
  logic [1:0]  s_rresp;
  logic        s_rlast;
  logic        s_rvalid;
  logic        s_rready;
  logic [31:0] m_rdata;
  logic [3:0]  m_rid;
  logic [1:0]  m_rresp;
  logic        m_rlast;
  logic [2:0]  m_rvalid;
  logic [2:0]  m_rready;
  logic        rd_state_refre;
  logic        len_err;

  int tests_run = 0;
  int tests_failed = 0;

  rd_return_router #(.DATA_W(32), .ID_W(4)) dut (
    .sys_clk        (sys_clk),
    .sys_rst        (sys_rst),
    .rd_grant       (rd_grant),
    .ar_len         (ar_len),
    .ar_hs          (ar_hs),
    .s_rdata        (s_rdata),
    .s_rid          (s_rid),
    .s_rresp        (s_rresp),
    .s_rlast        (s_rlast),
    .s_rvalid       (s_rvalid),
    .s_rready       (s_rready),
    .m_rdata        (m_rdata),
    .m_rid          (m_rid),
    .m_rresp        (m_rresp),
    .m_rlast        (m_rlast),
    .m_rvalid       (m_rvalid),
    .m_rready       (m_rready),
    .rd_state_refre (rd_state_refre),
    .len_err        (len_err)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  // Present one slave beat that the owning master accepts in this cycle.
  task automatic do_beat(input string tag, input logic [2:0] exp_v, input logic [31:0] d,
                         input logic last, input logic exp_last, input logic exp_err);
    s_rvalid = 1'b1;
    s_rdata  = d;
    s_rid    = d[3:0];
    s_rresp  = d[5:4];
    s_rlast  = last;
    #1;
    chk({tag, " m_rvalid"}, m_rvalid, exp_v);
    chk({tag, " s_rready"}, s_rready, 1'b1);
    chk({tag, " m_rdata"},  m_rdata, d);
    chk({tag, " m_rid"},    m_rid, d[3:0]);
    chk({tag, " m_rresp"},  m_rresp, d[5:4]);
    chk({tag, " m_rlast"},  m_rlast, exp_last);
    chk({tag, " len_err"},  len_err, exp_err);
    chk({tag, " refre"},    rd_state_refre, 1'b0);
    tick();
    s_rvalid = 1'b0;
    s_rlast  = 1'b0;
  endtask

  task automatic start_burst(input logic [2:0] g, input logic [7:0] len);
    rd_grant = g;
    ar_hs    = 1'b1;
    ar_len   = len;
    m_rready = g;
    tick();
    ar_hs    = 1'b0;
  endtask

  task automatic expect_refre(input string tag);
    rd_grant = 3'b000;
    #1;
    chk({tag, " refre pulse"}, rd_state_refre, 1'b1);
    chk({tag, " release valid"}, m_rvalid, 3'b000);
    tick();
    chk({tag, " refre single"}, rd_state_refre, 1'b0);
  endtask

  initial begin
    sys_rst  = 1'b1;
    rd_grant = 3'b000;
    ar_len   = 8'd0;
    ar_hs    = 1'b0;
    s_rdata  = 32'd0;
    s_rid    = 4'd0;
    s_rresp  = 2'd0;
    s_rlast  = 1'b0;
    s_rvalid = 1'b0;
    m_rready = 3'b000;
    #1;
    chk("reset s_rready", s_rready, 1'b0);
    chk("reset m_rvalid", m_rvalid, 3'b000);
    chk("reset refre",    rd_state_refre, 1'b0);
    chk("reset len_err",  len_err, 1'b0);
    tick();
    tick();
    sys_rst = 1'b0;
    tick();

    // Nominal: master 1, ARLEN 3, RLAST on beat 4.
    start_burst(3'b010, 8'd3);
    do_beat("nom b1", 3'b010, 32'hA000_0011, 1'b0, 1'b0, 1'b0);
    do_beat("nom b2", 3'b010, 32'hA000_0022, 1'b0, 1'b0, 1'b0);
    do_beat("nom b3", 3'b010, 32'hA000_0033, 1'b0, 1'b0, 1'b0);
    do_beat("nom b4", 3'b010, 32'hA000_0004, 1'b1, 1'b1, 1'b0);
    expect_refre("nom");

    // Backpressure: master 1 stalls 3 cycles after beat 1.
    start_burst(3'b010, 8'd3);
    do_beat("bp b1", 3'b010, 32'hB000_0001, 1'b0, 1'b0, 1'b0);
    m_rready = 3'b000;
    s_rvalid = 1'b1;
    s_rdata  = 32'hB000_0002;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp stall s_rready", s_rready, 1'b0);
      chk("bp stall m_rvalid", m_rvalid, 3'b010);
      chk("bp stall m_rdata",  m_rdata, 32'hB000_0002);
      tick();
    end
    m_rready = 3'b010;
    do_beat("bp b2", 3'b010, 32'hB000_0002, 1'b0, 1'b0, 1'b0);
    do_beat("bp b3", 3'b010, 32'hB000_0003, 1'b0, 1'b0, 1'b0);
    do_beat("bp b4", 3'b010, 32'hB000_0004, 1'b1, 1'b1, 1'b0);
    expect_refre("bp");

    // Early RLAST on beat 2 of a 4-beat burst.
    start_burst(3'b001, 8'd3);
    do_beat("early b1", 3'b001, 32'hC000_0001, 1'b0, 1'b0, 1'b0);
    do_beat("early b2", 3'b001, 32'hC000_0002, 1'b1, 1'b1, 1'b1);
    expect_refre("early");

    // Missing RLAST: ARLEN 1, slave never raises RLAST.
    start_burst(3'b100, 8'd1);
    do_beat("miss b1", 3'b100, 32'hD000_0001, 1'b0, 1'b0, 1'b0);
    do_beat("miss b2", 3'b100, 32'hD000_0002, 1'b0, 1'b1, 1'b1);
    s_rvalid = 1'b1;
    s_rdata  = 32'hD000_0003;
    #1;
    chk("miss b3 s_rready", s_rready, 1'b0);
    expect_refre("miss");
    chk("miss b3 idle s_rready", s_rready, 1'b0);
    chk("miss b3 idle m_rvalid", m_rvalid, 3'b000);
    s_rvalid = 1'b0;

    // Multi-hot grant is ignored even with an AR handshake.
    rd_grant = 3'b011;
    ar_hs    = 1'b1;
    ar_len   = 8'd0;
    tick();
    rd_grant = 3'b000;
    ar_hs    = 1'b0;
    m_rready = 3'b111;
    s_rvalid = 1'b1;
    #1;
    chk("multihot s_rready", s_rready, 1'b0);
    chk("multihot m_rvalid", m_rvalid, 3'b000);
    s_rvalid = 1'b0;
    tick();

    // Grant withdrawn before AR, then grant+AR in the same cycle.
    rd_grant = 3'b001;
    m_rready = 3'b001;
    tick();
    s_rvalid = 1'b1;
    #1;
    chk("wait_ar s_rready", s_rready, 1'b0);
    chk("wait_ar m_rvalid", m_rvalid, 3'b000);
    s_rvalid = 1'b0;
    rd_grant = 3'b000;
    tick();
    chk("withdraw refre a", rd_state_refre, 1'b0);
    tick();
    chk("withdraw refre b", rd_state_refre, 1'b0);
    start_burst(3'b100, 8'd0);
    rd_grant = 3'b001;
    do_beat("single b1", 3'b100, 32'hE000_0001, 1'b1, 1'b1, 1'b0);
    expect_refre("single");

    // Reset asserted during beat 2 of an 8-beat burst.
    start_burst(3'b001, 8'd7);
    do_beat("rst b1", 3'b001, 32'hF000_0001, 1'b0, 1'b0, 1'b0);
    s_rvalid = 1'b1;
    s_rdata  = 32'hF000_0002;
    #1;
    chk("rst b2 m_rvalid before", m_rvalid, 3'b001);
    sys_rst = 1'b1;
    #1;
    chk("rst async m_rvalid", m_rvalid, 3'b000);
    chk("rst async s_rready", s_rready, 1'b0);
    chk("rst async refre",    rd_state_refre, 1'b0);
    tick();
    chk("rst held refre", rd_state_refre, 1'b0);
    s_rvalid = 1'b0;
    sys_rst  = 1'b0;
    tick();
    chk("rst after refre", rd_state_refre, 1'b0);
    start_burst(3'b001, 8'd1);
    do_beat("post b1", 3'b001, 32'h1234_5601, 1'b0, 1'b0, 1'b0);
    do_beat("post b2", 3'b001, 32'h1234_5602, 1'b1, 1'b1, 1'b0);
    expect_refre("post");

    // Maximum length: ARLEN 255 gives 256 beats, RLAST only on the last.
    start_burst(3'b010, 8'd255);
    for (int i = 0; i < 255; i++) begin
      s_rvalid = 1'b1;
      s_rlast  = 1'b0;
      #1;
      tests_run++;
      assert (m_rlast === 1'b0 && len_err === 1'b0 && s_rready === 1'b1) else begin
        tests_failed++;
        $error("FAIL max beat %0d observed rlast=%b err=%b rdy=%b expected 0 0 1", i, m_rlast, len_err, s_rready);
      end
      tick();
    end
    do_beat("max b256", 3'b010, 32'h0000_FFFF, 1'b1, 1'b1, 1'b0);
    expect_refre("max");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
